mem_arbiter: RTL and testbench

Shares one `mem_ctrl` port between the instruction-fetch requester (IF) and the load/store requester (MEM) of `riscv_cpu`. It accepts a request from each side, grants one, and issues a single read or write to `mem_ctrl`. It then waits for `done`, returns read data and a one-cycle done pulse to the granted requester, and re-arbitrates. It sits between `riscv_cpu` and port 0 of `mem_ctrl` in `cpu`.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM arbiter in front of mem_ctrl port 0.
package mem_arbiter_pkg;

    localparam int unsigned RW_W = 2;

    typedef enum logic [RW_W-1:0] {
        MEM_RW_NONE  = 2'b00,
        MEM_RW_READ  = 2'b01,
        MEM_RW_WRITE = 2'b10
    } mem_rw_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and mem_ctrl-side signals of mem_arbiter; master is the arbiter view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_done_o;

    logic              dm_req_i;
    logic              dm_rwe_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [MASK_W-1:0] dm_sel_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_data_o;
    logic              dm_done_o;

    logic [RW_W-1:0]   mc_rw_flag_o;
    logic [ADDR_W-1:0] mc_addr_o;
    logic [DATA_W-1:0] mc_wdata_o;
    logic [MASK_W-1:0] mc_mask_o;
    logic [DATA_W-1:0] mc_rdata_i;
    logic              mc_busy_i;
    logic              mc_done_i;

    modport master (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_data_o, if_done_o,
        input  dm_req_i, dm_rwe_i, dm_addr_i, dm_sel_i, dm_wdata_i,
        output dm_data_o, dm_done_o,
        output mc_rw_flag_o, mc_addr_o, mc_wdata_o, mc_mask_o,
        input  mc_rdata_i, mc_busy_i, mc_done_i
    );

    modport slave (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_data_o, if_done_o,
        output dm_req_i, dm_rwe_i, dm_addr_i, dm_sel_i, dm_wdata_i,
        input  dm_data_o, dm_done_o,
        input  mc_rw_flag_o, mc_addr_o, mc_wdata_o, mc_mask_o,
        output mc_rdata_i, mc_busy_i, mc_done_i
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one mem_ctrl port between IF and MEM requesters, one transaction at a time.
// MEM_ARB_RR_EN: round-robin on simultaneous requests; otherwise MEM has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
)(
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.master  bus
);
    localparam int unsigned MASK_W = DATA_W / 8;

    arb_state_e        state;
    gnt_e              gnt;
    mem_rw_e           cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [MASK_W-1:0] cmd_mask;
    logic              drop;
    logic [DATA_W-1:0] if_data;
    logic              if_done;
    logic [DATA_W-1:0] dm_data;
    logic              dm_done;

    logic if_pend;
    logic dm_pend;
    logic any_req;
    gnt_e pick;

    // A flush in IDLE cancels that cycle's fetch request before arbitration.
    assign if_pend = bus.if_req_i & ~bus.if_flush_i;
    assign dm_pend = bus.dm_req_i;
    assign any_req = if_pend | dm_pend;

`ifdef MEM_ARB_RR_EN
    gnt_e rr_ptr;

    always_comb begin
        pick = GNT_IF;
        if (if_pend && dm_pend) pick = rr_ptr;
        else if (dm_pend)       pick = GNT_DM;
    end

    // Pointer moves to the other requester after every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= GNT_DM;
        end else if (state == ARB_IDLE && any_req) begin
            rr_ptr <= (pick == GNT_DM) ? GNT_IF : GNT_DM;
        end
    end
`else
    always_comb begin
        pick = dm_pend ? GNT_DM : GNT_IF;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            gnt       <= GNT_IF;
            cmd_rw    <= MEM_RW_NONE;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_mask  <= '0;
            drop      <= 1'b0;
            if_data   <= '0;
            if_done   <= 1'b0;
            dm_data   <= '0;
            dm_done   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    drop <= 1'b0;
                    if (any_req) begin
                        gnt   <= pick;
                        state <= ARB_ISSUE;
                        if (pick == GNT_DM) begin
                            cmd_rw    <= bus.dm_rwe_i ? MEM_RW_WRITE : MEM_RW_READ;
                            cmd_addr  <= bus.dm_addr_i;
                            cmd_wdata <= bus.dm_wdata_i;
                            cmd_mask  <= bus.dm_sel_i;
                        end else begin
                            cmd_rw    <= MEM_RW_READ;
                            cmd_addr  <= bus.if_addr_i;
                            cmd_wdata <= '0;
                            cmd_mask  <= '1;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if (gnt == GNT_IF && bus.if_flush_i) drop <= 1'b1;
                    if (!bus.mc_busy_i) state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (gnt == GNT_IF && bus.if_flush_i) drop <= 1'b1;
                    if (bus.mc_done_i) begin
                        state <= ARB_IDLE;
                        drop  <= 1'b0;
                        if (gnt == GNT_DM) begin
                            dm_done <= 1'b1;
                            if (cmd_rw == MEM_RW_READ) dm_data <= bus.mc_rdata_i;
                        end else if (!(drop || bus.if_flush_i)) begin
                            if_done <= 1'b1;
                            if_data <= bus.mc_rdata_i;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // The command is offered only in the one ISSUE cycle mem_ctrl is free.
    assign bus.mc_rw_flag_o = (state == ARB_ISSUE && !bus.mc_busy_i) ? cmd_rw : MEM_RW_NONE;
    assign bus.mc_addr_o    = cmd_addr;
    assign bus.mc_wdata_o   = cmd_wdata;
    assign bus.mc_mask_o    = cmd_mask;
    assign bus.if_data_o    = if_data;
    assign bus.if_done_o    = if_done;
    assign bus.dm_data_o    = dm_data;
    assign bus.dm_done_o    = dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic        dm;
        logic        rwe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          busy;
        int          lat;
        int          flush_at;
        int          drop_at;
        logic [1:0]  e_flag;
        int          e_if;
        int          e_dm;
        logic [31:0] e_if_data;
        logic [31:0] e_dm_data;
        int          e_done_c;
    } vec_t;

    vec_t vecs [8];

    int passed = 0;
    int total  = 0;

    // mem_ctrl model state and observation log
    int          busy_n;
    int          lat;
    int          done_at;
    logic [31:0] rdata_v;
    int          n_flag, n_if, n_dm, if_c, dm_c;
    logic [1:0]  flag_v    [8];
    int          flag_cyc  [8];
    logic [31:0] flag_addr [8];
    logic [31:0] flag_wdata[8];
    logic [3:0]  flag_mask [8];
    logic [31:0] wait_addr, wait_wdata;
    logic [3:0]  wait_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.if_flush_i = 1'b0;
        bus.dm_req_i   = 1'b0;
        bus.dm_rwe_i   = 1'b0;
        bus.dm_addr_i  = '0;
        bus.dm_sel_i   = '0;
        bus.dm_wdata_i = '0;
    endtask

    task automatic init_run();
        clear_inputs();
        busy_n = 0; lat = 1; done_at = -100; rdata_v = '0;
        n_flag = 0; n_if = 0; n_dm = 0; if_c = -1; dm_c = -1;
        wait_addr = '0; wait_wdata = '0; wait_mask = '0;
    endtask

    // One cycle: drive mem_ctrl side at negedge, then observe DUT outputs.
    task automatic tick(input int c);
        @(negedge clk);
        bus.mc_busy_i  = (c >= 1 && c <= busy_n);
        bus.mc_done_i  = (c == done_at);
        bus.mc_rdata_i = (c == done_at) ? rdata_v : 32'hBAD0_BAD0;
        #1;
        if (c == done_at) begin
            wait_addr  = bus.mc_addr_o;
            wait_wdata = bus.mc_wdata_o;
            wait_mask  = bus.mc_mask_o;
        end
        if (bus.mc_rw_flag_o != 2'b00) begin
            if (n_flag < 8) begin
                flag_v[n_flag]     = bus.mc_rw_flag_o;
                flag_cyc[n_flag]   = c;
                flag_addr[n_flag]  = bus.mc_addr_o;
                flag_wdata[n_flag] = bus.mc_wdata_o;
                flag_mask[n_flag]  = bus.mc_mask_o;
            end
            n_flag++;
            done_at = c + lat;
        end
        if (bus.if_done_o) begin n_if++; if_c = c; end
        if (bus.dm_done_o) begin n_dm++; dm_c = c; end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic req_on;
        init_run();
        busy_n  = v.busy;
        lat     = v.lat;
        rdata_v = v.rdata;
        for (int c = 0; c < 48; c++) begin
            tick(c);
            req_on = (n_if + n_dm == 0) && !(done_at >= 0 && c > done_at) && (c < v.drop_at);
            bus.if_req_i   = !v.dm && req_on;
            bus.if_addr_i  = v.dm ? 32'h0 : v.addr;
            bus.dm_req_i   = v.dm && req_on;
            bus.dm_rwe_i   = v.dm && v.rwe;
            bus.dm_addr_i  = v.dm ? v.addr : 32'h0;
            bus.dm_wdata_i = v.dm ? v.wdata : 32'h0;
            bus.dm_sel_i   = v.dm ? v.sel : 4'h0;
            bus.if_flush_i = (c == v.flush_at);
            if (done_at >= 0 && c >= done_at + 3) break;
        end
        clear_inputs();
        check($sformatf("v%0d flag_count", idx), n_flag, 1);
        check($sformatf("v%0d flag_value", idx), flag_v[0], v.e_flag);
        check($sformatf("v%0d flag_cycle", idx), flag_cyc[0], v.busy + 1);
        check($sformatf("v%0d issue_addr", idx), flag_addr[0], v.addr);
        check($sformatf("v%0d issue_mask", idx), flag_mask[0], v.dm ? v.sel : 4'hF);
        check($sformatf("v%0d issue_wdata", idx), flag_wdata[0], v.dm ? v.wdata : 32'h0);
        check($sformatf("v%0d wait_addr", idx), wait_addr, v.addr);
        check($sformatf("v%0d wait_mask", idx), wait_mask, v.dm ? v.sel : 4'hF);
        check($sformatf("v%0d wait_wdata", idx), wait_wdata, v.dm ? v.wdata : 32'h0);
        check($sformatf("v%0d if_done_count", idx), n_if, v.e_if);
        check($sformatf("v%0d dm_done_count", idx), n_dm, v.e_dm);
        check($sformatf("v%0d if_data", idx), bus.if_data_o, v.e_if_data);
        check($sformatf("v%0d dm_data", idx), bus.dm_data_o, v.e_dm_data);
        if (v.e_done_c >= 0)
            check($sformatf("v%0d done_cycle", idx), v.dm ? dm_c : if_c, v.e_done_c);
    endtask

    initial begin
        //           dm    rwe   addr          wdata         sel   rdata         bsy lat fl  drp  flag   if dm if_data       dm_data       done
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,        4'h0, 32'h1234_5678, 0, 3, -1, 99, 2'b01, 1, 0, 32'h1234_5678, 32'h0,        5};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 32'h9999_9999, 0, 2, -1, 99, 2'b10, 0, 1, 32'h1234_5678, 32'h0,        4};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h7777_7777, 4'hF, 32'hCAFE_F00D, 0, 1, -1, 99, 2'b01, 0, 1, 32'h1234_5678, 32'hCAFE_F00D, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'h0, 32'h0BAD_CAFE, 5, 2, -1, 99, 2'b01, 1, 0, 32'h0BAD_CAFE, 32'hCAFE_F00D, 9};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0104, 32'h0102_0304, 4'hF, 32'h6666_6666, 2, 4, -1, 99, 2'b10, 0, 1, 32'h0BAD_CAFE, 32'hCAFE_F00D, 8};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,        4'h0, 32'hFFFF_0000, 0, 4,  3, 99, 2'b01, 0, 0, 32'h0BAD_CAFE, 32'hCAFE_F00D, -1};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hA5A5_A5A5, 2, 1,  1, 99, 2'b01, 0, 0, 32'h0BAD_CAFE, 32'hCAFE_F00D, -1};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        4'hC, 32'h55AA_55AA, 0, 3, -1,  2, 2'b01, 0, 1, 32'h0BAD_CAFE, 32'h55AA_55AA, 5};

        init_run();
        bus.mc_busy_i  = 1'b0;
        bus.mc_done_i  = 1'b0;
        bus.mc_rdata_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs",
              {bus.mc_rw_flag_o, bus.mc_addr_o, bus.mc_wdata_o, bus.mc_mask_o,
               bus.if_data_o, bus.if_done_o, bus.dm_data_o, bus.dm_done_o}, '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Flush during an IF read while MEM waits; MEM is granted right after done.
        init_run();
        lat = 3; rdata_v = 32'h1357_9BDF;
        for (int c = 0; c < 20; c++) begin
            tick(c);
            bus.if_req_i   = (c < 5);
            bus.if_addr_i  = 32'h0000_0040;
            bus.if_flush_i = (c == 2);
            bus.dm_req_i   = (c >= 1) && (dm_c < 0);
            bus.dm_rwe_i   = 1'b1;
            bus.dm_addr_i  = 32'h0000_0080;
            bus.dm_wdata_i = 32'h1111_2222;
            bus.dm_sel_i   = 4'hF;
        end
        clear_inputs();
        check("flushA flag_count", n_flag, 2);
        check("flushA if_done_count", n_if, 0);
        check("flushA if_data", bus.if_data_o, 32'h0BAD_CAFE);
        check("flushA mem_issue_cycle", flag_cyc[1], 6);
        check("flushA mem_issue_flag", flag_v[1], 2'b10);
        check("flushA mem_issue_addr", flag_addr[1], 32'h0000_0080);
        check("flushA dm_done_cycle", dm_c, 10);
        check("flushA dm_data", bus.dm_data_o, 32'h55AA_55AA);

        // Simultaneous requests; MEM asks for two transactions, IF for one.
        init_run();
        lat = 2; rdata_v = 32'h2468_ACE0;
        for (int c = 0; c < 30; c++) begin
            tick(c);
            bus.if_req_i  = (n_if == 0);
            bus.if_addr_i = 32'h0000_0010;
            bus.dm_req_i  = (n_dm < 2);
            bus.dm_addr_i = 32'h0000_0020;
            bus.dm_sel_i  = 4'hF;
        end
        clear_inputs();
        check("arb flag_count", n_flag, 3);
        check("arb grant0", flag_addr[0], 32'h0000_0020);
`ifdef MEM_ARB_RR_EN
        check("arb grant1", flag_addr[1], 32'h0000_0010);
        check("arb grant2", flag_addr[2], 32'h0000_0020);
`else
        check("arb grant1", flag_addr[1], 32'h0000_0020);
        check("arb grant2", flag_addr[2], 32'h0000_0010);
`endif
        check("arb issue1_cycle", flag_cyc[1], 5);
        check("arb issue2_cycle", flag_cyc[2], 9);
        check("arb if_data", bus.if_data_o, 32'h2468_ACE0);

        // Flush in IDLE blocks the fetch; a stray mc_done in IDLE is ignored.
        init_run();
        lat = 1; rdata_v = 32'h0F0F_0F0F; done_at = 1;
        for (int c = 0; c < 3; c++) begin
            tick(c);
            bus.if_req_i   = 1'b1;
            bus.if_addr_i  = 32'h0000_0050;
            bus.if_flush_i = 1'b1;
        end
        tick(3);
        check("idle_flush no_issue", n_flag, 0);
        check("idle_done ignored", n_if + n_dm, 0);
        bus.if_flush_i = 1'b0;
        for (int c = 4; c < 10; c++) begin
            tick(c);
            bus.if_req_i = (n_if == 0);
        end
        clear_inputs();
        check("idle_flush issue_cycle", flag_cyc[0], 4);
        check("idle_flush if_done_count", n_if, 1);
        check("idle_flush if_data", bus.if_data_o, 32'h0F0F_0F0F);

        // Asynchronous reset in WAIT abandons the transaction.
        init_run();
        lat = 10; rdata_v = 32'hDEAD_DEAD;
        tick(0);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0060;
        for (int c = 1; c < 4; c++) tick(c);
        rst = 1'b1;
        #1;
        check("rst mc_addr", bus.mc_addr_o, 32'h0);
        check("rst all_outputs",
              {bus.mc_rw_flag_o, bus.mc_addr_o, bus.mc_wdata_o, bus.mc_mask_o,
               bus.if_data_o, bus.if_done_o, bus.dm_data_o, bus.dm_done_o}, '0);
        bus.if_req_i = 1'b0;
        tick(4);
        tick(5);
        rst = 1'b0;
        for (int c = 6; c < 15; c++) tick(c);
        check("rst no_done", n_if + n_dm, 0);
        check("rst no_reissue", n_flag, 1);
        lat = 1; rdata_v = 32'h3141_5926;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0070;
        for (int c = 15; c < 20; c++) begin
            tick(c);
            bus.if_req_i = (n_if == 0);
        end
        clear_inputs();
        check("rst idle_issue_cycle", flag_cyc[1], 15);
        check("rst idle_issue_flag", flag_v[1], 2'b01);
        check("rst if_data", bus.if_data_o, 32'h3141_5926);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
